// File: rtl/gbsha_fir.sv
// gbsha_fir: N-tap unsigned FIR filter with shift-loaded coefficients.
// Registered result with a one-cycle valid strobe and a primed flag.
module gbsha_fir #(
    parameter int N_TAPS = 4,
    parameter int W_IN   = 2,
    parameter int W_COEF = 3,
    localparam int W_OUT = W_IN + W_COEF + $clog2(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_IN-1:0]   x_in,
    input  logic              x_valid,
    input  logic [W_COEF-1:0] coef_in,
    input  logic              coef_load,
    input  logic              clr,
    output logic [W_OUT-1:0]  y_out,
    output logic              y_valid,
    output logic              y_primed
);

    localparam int CW = $clog2(N_TAPS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_TAPS);

    logic [W_IN-1:0]   d     [N_TAPS];
    logic [W_IN-1:0]   d_nxt [N_TAPS];
    logic [W_COEF-1:0] c     [N_TAPS];
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [W_OUT-1:0]  acc;

    // Post-shift delay line and the full-precision dot product over it.
    always_comb begin
        d_nxt[0] = x_in;
        for (int k = 1; k < N_TAPS; k++) begin
            d_nxt[k] = d[k-1];
        end
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc = acc + W_OUT'(c[k]) * W_OUT'(d_nxt[k]);
        end
    end

    // Saturating count of accepted samples.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // One action per edge: clear, then coefficient shift, then sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d[k] <= '0;
                c[k] <= W_COEF'(1);
            end
            cnt      <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            y_primed <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d[k] <= '0;
            end
            cnt      <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            y_primed <= 1'b0;
        end else if (coef_load) begin
            c[0] <= coef_in;
            for (int k = 1; k < N_TAPS; k++) begin
                c[k] <= c[k-1];
            end
            y_valid <= 1'b0;
        end else if (x_valid) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d[k] <= d_nxt[k];
            end
            cnt      <= cnt_nxt;
            y_out    <= acc;
            y_valid  <= 1'b1;
            y_primed <= (cnt_nxt == CNT_MAX);
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gbsha_fir.sv
// tb_gbsha_fir: directed scenarios plus random traffic for gbsha_fir,
// compared every cycle against an array-based behavioural model.
module tb_gbsha_fir;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] x_in;
    logic       x_valid;
    logic [2:0] coef_in;
    logic       coef_load;
    logic       clr;
    logic [6:0] y_out;
    logic       y_valid;
    logic       y_primed;

    int n_chk = 0;
    int n_err = 0;

    int md [N];
    int mc [N];
    int mcnt, my, mv, mp;

    always #5 clk = ~clk;

    gbsha_fir dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .coef_in   (coef_in),
        .coef_load (coef_load),
        .clr       (clr),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_primed  (y_primed)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            md[k] = 0;
            mc[k] = 1;
        end
        mcnt = 0;
        my = 0;
        mv = 0;
        mp = 0;
    endtask

    task automatic model_edge(input int c_r, input int l_r,
                              input int v_r, input int xv, input int cv);
        if (c_r != 0) begin
            for (int k = 0; k < N; k++) md[k] = 0;
            mcnt = 0;
            my = 0;
            mv = 0;
            mp = 0;
        end else if (l_r != 0) begin
            for (int k = N - 1; k > 0; k--) mc[k] = mc[k-1];
            mc[0] = cv;
            mv = 0;
        end else if (v_r != 0) begin
            for (int k = N - 1; k > 0; k--) md[k] = md[k-1];
            md[0] = xv;
            my = 0;
            for (int k = 0; k < N; k++) my += mc[k] * md[k];
            mv = 1;
            if (mcnt < N) mcnt++;
            mp = (mcnt == N) ? 1 : 0;
        end else begin
            mv = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y_out"}, int'(y_out), my);
        chk({tag, ".y_valid"}, int'(y_valid), mv);
        chk({tag, ".y_primed"}, int'(y_primed), mp);
    endtask

    task automatic step(input string tag, input logic c_r, input logic l_r,
                        input logic v_r, input int xv, input int cv);
        clr = c_r;
        coef_load = l_r;
        x_valid = v_r;
        x_in = 2'(xv);
        coef_in = 3'(cv);
        @(posedge clk);
        #1;
        model_edge(int'(c_r), int'(l_r), int'(v_r), xv, cv);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic sample(input string tag, input int xv);
        step(tag, 1'b0, 1'b0, 1'b1, xv, 0);
    endtask

    task automatic load(input string tag, input int cv);
        step(tag, 1'b0, 1'b1, 1'b0, 0, cv);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        x_in = '0;
        x_valid = 1'b0;
        coef_in = '0;
        coef_load = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) sample("dflt", 3);
        chk("dflt.final", int'(y_out), 12);
        chk("dflt.primed", int'(y_primed), 1);
        idle("dflt.idle");

        sample("mid", 2);
        do_reset("midrst");
        sample("impulse", 1);
        chk("impulse.val", int'(y_out), 1);
        idle("impulse.idle");

        step("clr0", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) load("cload", i);
        sample("ctap0", 1);
        chk("ctap0.val", int'(y_out), 4);
        for (int i = 0; i < 3; i++) sample("ctap", 0);
        chk("ctap3.val", int'(y_out), 1);

        do_reset("rst2");
        sample("gap", 2);
        for (int i = 0; i < 3; i++) idle("gap.idle");
        chk("gap.hold", int'(y_out), 2);
        sample("gap2", 2);
        chk("gap2.val", int'(y_out), 4);

        sample("prio", 1);
        step("prio.clr", 1'b1, 1'b0, 1'b1, 3, 0);
        chk("prio.clr.y", int'(y_out), 0);
        step("prio.load", 1'b0, 1'b1, 1'b1, 3, 5);
        chk("prio.load.v", int'(y_valid), 0);
        step("prio.all", 1'b1, 1'b1, 1'b1, 2, 6);

        step("max.clr", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) load("max.load", 7);
        for (int i = 0; i < 4; i++) sample("max", 3);
        chk("max.val", int'(y_out), 84);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rnd.rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 60,
                     int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
